// File: rtl/shreg_pkg.sv
// Shared types for the sequenced shift register.
//   shreg_op_e    : command opcode as carried on cmd_op
//   shreg_state_e : sequencer state, also exported on the top's dbg_state port
//   is_shift_op() : true for opcodes that run through the SHIFT state
// Optional feature macro: SHREG_ROTATE_EN (rotate opcodes become real shifts).
package shreg_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_SAR  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_RSVD = 3'b111
  } shreg_op_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shreg_state_e;

  // Opcodes that step the register bit by bit. Without the rotate feature
  // ROR/ROL fall into the default and behave like NOP.
  function automatic logic is_shift_op(shreg_op_e op);
    case (op)
      OP_SHR, OP_SHL, OP_SAR: return 1'b1;
`ifdef SHREG_ROTATE_EN
      OP_ROR, OP_ROL:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step unit: one bit of shift/rotate.
//   po      in  WIDTH  current register value
//   op      in  3      operation (shreg_op_e)
//   sin     in  1      serial fill bit for SHR/SHL
//   next_po out WIDTH  register value after one step
//   out_bit out 1      bit ejected by this step
// Rotate datapath only present when SHREG_ROTATE_EN is defined.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] po,
  input  shreg_op_e        op,
  input  logic             sin,
  output logic [WIDTH-1:0] next_po,
  output logic             out_bit
);

  always_comb begin
    next_po = po;
    out_bit = 1'b0;
    case (op)
      OP_SHR: begin
        next_po = {sin, po[WIDTH-1:1]};
        out_bit = po[0];
      end
      OP_SHL: begin
        next_po = {po[WIDTH-2:0], sin};
        out_bit = po[WIDTH-1];
      end
      OP_SAR: begin
        // Sign bit replicates; sin plays no part.
        next_po = {po[WIDTH-1], po[WIDTH-1:1]};
        out_bit = po[0];
      end
`ifdef SHREG_ROTATE_EN
      OP_ROR: begin
        next_po = {po[0], po[WIDTH-1:1]};
        out_bit = po[0];
      end
      OP_ROL: begin
        next_po = {po[WIDTH-2:0], po[WIDTH-1]};
        out_bit = po[WIDTH-1];
      end
`endif
      default: begin
        next_po = po;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_reg_seq.sv
// Sequenced shift register: runs a multi-bit shift/load command one bit per
// clock behind a valid/ready command port.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_amt : command port
//   pi           : parallel load data (sampled at the accept edge)
//   sin          : serial fill bit (sampled live on each step)
//   po, sout     : register contents and last ejected bit
//   busy, done   : ~cmd_ready, one-cycle completion pulse
//   dbg_state    : current sequencer state
// Optional feature macro: SHREG_ROTATE_EN.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE and does not
// depend on cmd_valid; cmd_valid while busy is dropped, never queued.
module shift_reg_seq
  import shreg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] pi,
  input  logic             sin,
  output logic [WIDTH-1:0] po,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output shreg_state_e     dbg_state
);

  shreg_state_e     state_q, state_d;
  shreg_op_e        op_q, op_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  shreg_op_e        cmd_op_e;
  logic             accept;
  logic             shift_go;
  logic [AW-1:0]    sat_amt;
  logic [WIDTH-1:0] step_po;
  logic             step_bit;

  assign cmd_op_e = shreg_op_e'(cmd_op);
  assign accept   = cmd_valid && (state_q == ST_IDLE);
  assign shift_go = is_shift_op(cmd_op_e) && (cmd_amt != '0);
  assign sat_amt  = (cmd_amt > AW'(WIDTH)) ? AW'(WIDTH) : cmd_amt;

  shreg_step #(.WIDTH(WIDTH)) u_step (
    .po      (po_q),
    .op      (op_q),
    .sin     (sin),
    .next_po (step_po),
    .out_bit (step_bit)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      po_q    <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      po_q    <= po_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && shift_go) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == AW'(1))    state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    op_d   = op_q;
    cnt_d  = cnt_q;
    po_d   = po_q;
    sout_d = sout_q;
    done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd_op_e == OP_LOAD) begin
            po_d   = pi;
            done_d = 1'b1;
          end else if (shift_go) begin
            op_d  = cmd_op_e;
            cnt_d = sat_amt;
          end else begin
            // NOP, reserved, disabled rotate, or zero-length shift.
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        po_d   = step_po;
        sout_d = step_bit;
        cnt_d  = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    po        = po_q;
    sout      = sout_q;
    done      = done_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;
  import shreg_pkg::*;

  localparam int W  = 8;
  localparam int AW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_amt = '0;
  logic [W-1:0]  pi = '0;
  logic          sin = 1'b0;
  logic [W-1:0]  po;
  logic          sout;
  logic          busy;
  logic          done;
  shreg_state_e  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference register state
  logic [W-1:0] m_po = '0;
  logic         m_sout = 1'b0;

  shift_reg_seq #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .pi(pi), .sin(sin), .po(po),
    .sout(sout), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Whole-command model: final value computed from shift arithmetic, not stepping.
  task automatic model(input logic [2:0] op, input logic [AW-1:0] amt,
                       input logic [W-1:0] din, input logic s, output int k);
    logic [W-1:0] ones;
    logic [W-1:0] p;
    bit rot_en;
    ones = '1;
    p = m_po;
`ifdef SHREG_ROTATE_EN
    rot_en = 1;
`else
    rot_en = 0;
`endif
    k = (amt > W) ? W : int'(amt);
    if (!(op == 3'd1 || op == 3'd2 || op == 3'd4 || (rot_en && (op == 3'd5 || op == 3'd6))))
      k = 0;
    if (op == 3'd3) m_po = din;
    if (k > 0) begin
      case (op)
        3'd1: begin m_po = (p >> k) | (s ? ~(ones >> k) : '0); m_sout = p[k-1]; end
        3'd2: begin m_po = (p << k) | (s ? ~(ones << k) : '0); m_sout = p[W-k]; end
        3'd4: begin m_po = W'($signed(p) >>> k);               m_sout = p[k-1]; end
        3'd5: begin m_po = (p >> k) | (p << (W-k));           m_sout = p[k-1]; end
        3'd6: begin m_po = (p << k) | (p >> (W-k));           m_sout = p[W-k]; end
        default: ;
      endcase
    end
  endtask

  // Issue one command (caller is #1 after an edge with cmd_ready high) and
  // follow it to its done pulse. Ends on the done sample.
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] amt,
                         input logic [W-1:0] din, input logic s, input bit inject);
    int k;
    int cyc;
    int low;
    bit got;
    model(op, amt, din, s, k);
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_amt = amt; pi = din; sin = s;
    @(posedge clk); #1;
    cmd_valid = 0;
    pi = W'($urandom);
    got = 0; low = 0; cyc = 0;
    for (int c = 1; c <= 3 * W; c++) begin
      if (!cmd_ready) low++;
      if (done) begin got = 1; cyc = c; break; end
      // A command offered while busy must be ignored.
      if (inject && k >= 2 && c == 1) begin cmd_valid = 1; cmd_op = 3'd3; pi = W'($urandom); end
      if (inject && k >= 2 && c == 2) cmd_valid = 0;
      @(posedge clk); #1;
    end
    check("done_seen", got, 1);
    check("latency", cyc, k + 1);
    check("busy_cycles", low, k);
    check("po", po, m_po);
    check("sout", sout, m_sout);
    check("ready_at_done", cmd_ready, 1);
    check("busy_at_done", busy, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_single", done, 0);
  endtask

  task automatic reset_mid_cmd();
    run_cmd(3'd3, 0, 8'hFF, 0, 0);
    idle_cycle();
    cmd_valid = 1; cmd_op = 3'd1; cmd_amt = 6; sin = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 0;
    check("mid_busy", busy, 1);
    repeat (2) begin
      @(posedge clk); #1;
      check("mid_no_done", done, 0);
    end
    reset = 1;
    @(posedge clk); #1;
    check("rst_no_done", done, 0);
    @(posedge clk); #1;
    reset = 0;
    m_po = '0; m_sout = 1'b0;
    check("rst_po", po, 8'h00);
    check("rst_sout", sout, 0);
    check("rst_ready", cmd_ready, 1);
    repeat (6) begin
      @(posedge clk); #1;
      check("post_rst_done", done, 0);
    end
    check("post_rst_po", po, 8'h00);
  endtask

  initial begin
    // reset
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_po", po, 8'h00);
    check("reset_sout", sout, 0);
    check("reset_done", done, 0);
    check("reset_ready", cmd_ready, 1);
    reset = 0;
    @(posedge clk); #1;

    // directed
    run_cmd(3'd3, 0, 8'hA5, 0, 0);
    check("load_a5", po, 8'hA5);
    idle_cycle();
    run_cmd(3'd2, 3, 8'h00, 1, 0);
    check("shl3_po", po, 8'h2F);
    check("shl3_sout", sout, 1);
    idle_cycle();
    run_cmd(3'd3, 0, 8'h84, 0, 0);
    run_cmd(3'd4, 2, 8'h00, 1, 1);
    check("sar2_po", po, 8'hE1);
    check("sar2_sout", sout, 0);
    idle_cycle();
    run_cmd(3'd3, 0, 8'h81, 0, 0);
    run_cmd(3'd5, 1, 8'h00, 0, 0);
`ifdef SHREG_ROTATE_EN
    check("ror1_po", po, 8'hC0);
`else
    check("ror1_po", po, 8'h81);
`endif
    idle_cycle();
    run_cmd(3'd1, 15, 8'h00, 1, 0);
    check("shr_sat_po", po, 8'hFF);
    idle_cycle();
    run_cmd(3'd7, 5, 8'h3C, 1, 0);
    idle_cycle();

    reset_mid_cmd();

    // random, sometimes back-to-back in the done cycle
    for (int i = 0; i < 80; i++) begin
      run_cmd(3'($urandom_range(0, 7)), AW'($urandom_range(0, 15)),
              W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
